// File: rtl/lcd_msg_scheduler_pkg.sv
// Shared constants for the LCD message scheduler: state encoding, source IDs,
// message geometry and the fixed-priority source picker.
package lcd_sched_pkg;

    localparam int CHAR_W   = 8;
    localparam int LINE_LEN = 16;
    localparam int MSG_W    = CHAR_W * LINE_LEN;
    localparam int NUM_SRC  = 3;
    localparam int TIMER_W  = 21;

    typedef logic [MSG_W-1:0] msg_t;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_SUBMIT = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam logic [1:0] SRC_RESULT = 2'd0;
    localparam logic [1:0] SRC_GUESS  = 2'd1;
    localparam logic [1:0] SRC_STATUS = 2'd2;

    localparam msg_t BLANK_MSG = {LINE_LEN{8'h20}};

    // Strict priority: result beats guess beats status; status may starve.
    function automatic logic [1:0] pick_source(input logic [NUM_SRC-1:0] pending);
        logic [1:0] src;
        src = SRC_RESULT;
        if (pending[0]) begin
            src = SRC_RESULT;
        end else if (pending[1]) begin
            src = SRC_GUESS;
        end else if (pending[2]) begin
            src = SRC_STATUS;
        end
        return src;
    endfunction

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// Request and LCD-side signals of the message scheduler, bundled for port use.
interface lcd_msg_scheduler_if;
    import lcd_sched_pkg::*;

    logic [NUM_SRC-1:0] req_valid;
    msg_t               req_msg0;
    msg_t               req_msg1;
    msg_t               req_msg2;
    msg_t               out_msg;
    logic               lcd_submit;
    logic               busy;
    logic [1:0]         grant_src;
    logic [NUM_SRC-1:0] grant_done;
    logic [NUM_SRC-1:0] req_overwrite;

    modport master (
        output req_valid, req_msg0, req_msg1, req_msg2,
        input  out_msg, lcd_submit, busy, grant_src, grant_done, req_overwrite
    );

    modport slave (
        input  req_valid, req_msg0, req_msg1, req_msg2,
        output out_msg, lcd_submit, busy, grant_src, grant_done, req_overwrite
    );

endinterface

// File: rtl/lcd_hold_timer.sv
// Loadable down counter that saturates at zero; one instance serves the
// power-up wait, the submit pulse width and the per-message hold.
module lcd_hold_timer #(
    parameter int               WIDTH       = 21,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Arbitrates three message sources onto one LCD controller that has no busy
// flag, so all pacing (power-up wait, submit width, hold) is timed here.
module lcd_msg_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int INIT_CYCLES   = 200000,
    parameter int SUBMIT_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1800000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_msg_scheduler_if.slave   bus
);

    localparam int TIMER_MAX = (1 << TIMER_W);

    if (INIT_CYCLES < 1 || SUBMIT_CYCLES < 1 || HOLD_CYCLES < 1 ||
        INIT_CYCLES > TIMER_MAX || SUBMIT_CYCLES > TIMER_MAX || HOLD_CYCLES > TIMER_MAX) begin : g_bad_param
        $error("lcd_msg_scheduler: cycle parameters must be in 1..2**21");
    end

    localparam logic [TIMER_W-1:0] INIT_LOAD   = TIMER_W'(INIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SUBMIT_LOAD = TIMER_W'(SUBMIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);

    logic [2:0]         state;
    logic [NUM_SRC-1:0] pending;
    msg_t               slot [NUM_SRC];
    msg_t               req_msg [NUM_SRC];
    msg_t               out_msg;
    logic               lcd_submit;
    logic [1:0]         grant_src;
    logic [NUM_SRC-1:0] grant_done;
    logic [NUM_SRC-1:0] req_overwrite;

    logic [1:0]         grant_idx;
    logic               do_grant;
    logic [NUM_SRC-1:0] grant_clear;
    msg_t               grant_msg;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;

    assign req_msg[0] = bus.req_msg0;
    assign req_msg[1] = bus.req_msg1;
    assign req_msg[2] = bus.req_msg2;

    assign grant_idx   = pick_source(pending);
    assign do_grant    = (state == ST_IDLE) && (pending != '0);
    assign grant_clear = do_grant ? (NUM_SRC'(1) << grant_idx) : '0;

    always_comb begin
        grant_msg = slot[0];
        case (grant_idx)
            SRC_GUESS:  grant_msg = slot[1];
            SRC_STATUS: grant_msg = slot[2];
            default:    grant_msg = slot[0];
        endcase
    end

    // Timer reloads happen only on the LOAD->SUBMIT and SUBMIT->HOLD transitions;
    // INIT uses the reset value and all other states just let it run down.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_LOAD: begin
                timer_load  = 1'b1;
                timer_value = SUBMIT_LOAD;
            end
            ST_SUBMIT: begin
                if (timer_zero) begin
                    timer_load  = 1'b1;
                    timer_value = HOLD_LOAD;
                end
            end
            default: begin
                timer_load  = 1'b0;
                timer_value = '0;
            end
        endcase
    end

    lcd_hold_timer #(
        .WIDTH       (TIMER_W),
        .RESET_VALUE (INIT_LOAD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // A write landing on the cycle its own slot is granted keeps pending set,
    // so the fresh message goes out on the following grant without an overwrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            req_overwrite <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot[i] <= BLANK_MSG;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                req_overwrite[i] <= 1'b0;
                if (bus.req_valid[i]) begin
                    slot[i]          <= req_msg[i];
                    pending[i]       <= 1'b1;
                    req_overwrite[i] <= pending[i] & ~grant_clear[i];
                end else if (grant_clear[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            out_msg    <= BLANK_MSG;
            lcd_submit <= 1'b0;
            grant_src  <= SRC_RESULT;
            grant_done <= '0;
        end else begin
            grant_done <= '0;
            case (state)
                ST_INIT: begin
                    if (timer_zero) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (do_grant) begin
                        out_msg   <= grant_msg;
                        grant_src <= grant_idx;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    lcd_submit <= 1'b1;
                    state      <= ST_SUBMIT;
                end
                ST_SUBMIT: begin
                    if (timer_zero) begin
                        lcd_submit <= 1'b0;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (timer_zero) begin
                        grant_done <= NUM_SRC'(1) << grant_src;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_INIT;
                    lcd_submit <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_msg       = out_msg;
    assign bus.lcd_submit    = lcd_submit;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.grant_src     = grant_src;
    assign bus.grant_done    = grant_done;
    assign bus.req_overwrite = req_overwrite;

endmodule
